obstacle_lane: RTL

- Consumes the horizontal scroll position `h_pos` of one obstacle lane and renders that lane's car into the VGA pixel stream.
- Detects pixel-level overlap between the car and the chicken sprite.
- Declares a sticky hit after a configurable number of consecutive overlapping frames.
- Sits directly downstream of the horizontal scroller. Feeds the pixel mixer (`car_pixel`) and the game-state controller (`hit`, `hit_pulse`).

---
 rtl/crossy_pkg.sv | 19 +
 rtl/wrap_span_cmp.sv | 30 +++
 rtl/obstacle_lane.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/crossy_pkg.sv
// Shared constants and lane-state encoding for the crossy game datapath.
// Sprite sizes here are defaults; blocks may override them through parameters.
package crossy_pkg;

  localparam int unsigned SCREEN_WIDTH   = 640;
  localparam int unsigned SCREEN_HEIGHT  = 480;

  localparam int unsigned CAR_W_DEF      = 32;
  localparam int unsigned CAR_H_DEF      = 16;
  localparam int unsigned LANE_Y_DEF     = 240;
  localparam int unsigned CHICK_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    StSafe    = 2'd0,
    StContact = 2'd1,
    StHit     = 2'd2
  } lane_state_e;

endpackage

// File: rtl/wrap_span_cmp.sv
// Combinational test of whether a position lies inside a span that wraps at a
// modulus. Positions and starts are assumed to be below the modulus.
module wrap_span_cmp #(
  parameter int unsigned PosW = 10
) (
  input  logic [PosW-1:0] i_pos,
  input  logic [PosW-1:0] i_start,
  input  logic [PosW:0]   i_width,
  input  logic [PosW:0]   i_modulus,
  output logic            o_in_span
);

  logic [PosW:0] w_pos;
  logic [PosW:0] w_start;
  logic [PosW:0] w_dist;

  always_comb begin
    w_pos   = {1'b0, i_pos};
    w_start = {1'b0, i_start};
    // One extra bit holds pos + modulus - start without overflow.
    if (w_pos >= w_start) begin
      w_dist = w_pos - w_start;
    end else begin
      w_dist = w_pos + i_modulus - w_start;
    end
  end

  assign o_in_span = (w_dist < i_width);

endmodule

// File: rtl/obstacle_lane.sv
// One scrolling obstacle lane: draws its car, detects overlap with the chicken
// and declares a sticky hit after HIT_FRAMES consecutive overlapping frames.
module obstacle_lane #(
  parameter int unsigned SCREEN_WIDTH = crossy_pkg::SCREEN_WIDTH,
  parameter int unsigned CAR_W        = crossy_pkg::CAR_W_DEF,
  parameter int unsigned CAR_H        = crossy_pkg::CAR_H_DEF,
  parameter int unsigned LANE_Y       = crossy_pkg::LANE_Y_DEF,
  parameter int unsigned CHICK_SIZE   = crossy_pkg::CHICK_SIZE_DEF,
  parameter int unsigned HIT_FRAMES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] h_pos,
  input  logic       vsync_pulse,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_active,
  input  logic [9:0] chick_x,
  input  logic [9:0] chick_y,
  input  logic       clear_hit,
  output logic       car_pixel,
  output logic       hit,
  output logic       hit_pulse
);

  import crossy_pkg::*;

  localparam int unsigned CntW = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES + 1) : 1;

  localparam logic [10:0]     ScrW     = 11'(SCREEN_WIDTH);
  localparam logic [10:0]     CarW     = 11'(CAR_W);
  localparam logic [10:0]     LaneTop  = 11'(LANE_Y);
  localparam logic [10:0]     LaneBot  = 11'(LANE_Y + CAR_H);
  localparam logic [10:0]     ChickSz  = 11'(CHICK_SIZE);
  localparam logic [CntW-1:0] HitCnt   = CntW'(HIT_FRAMES);

  logic [9:0]      r_car_x;
  logic            r_car_pixel;
  logic            r_overlap_flag;
  logic            r_hit;
  logic            r_hit_pulse;
  logic [CntW-1:0] r_frame_cnt;
  lane_state_e     r_state;

  logic        w_in_x;
  logic        w_in_y;
  logic        w_car_on;
  logic        w_chick_on;
  logic [10:0] w_px;
  logic [10:0] w_py;
  logic [10:0] w_cx;
  logic [10:0] w_cy;

  wrap_span_cmp #(
    .PosW (10)
  ) u_span (
    .i_pos     (pix_x),
    .i_start   (r_car_x),
    .i_width   (CarW),
    .i_modulus (ScrW),
    .o_in_span (w_in_x)
  );

  assign w_px = {1'b0, pix_x};
  assign w_py = {1'b0, pix_y};
  assign w_cx = {1'b0, chick_x};
  assign w_cy = {1'b0, chick_y};

  assign w_in_y     = (w_py >= LaneTop) && (w_py < LaneBot);
  assign w_car_on   = video_active && w_in_x && w_in_y;
  assign w_chick_on = (w_px >= w_cx) && (w_px < w_cx + ChickSz) &&
                      (w_py >= w_cy) && (w_py < w_cy + ChickSz);

  // Car position only moves at frame start so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_car_x <= '0;
    end else if (vsync_pulse) begin
      r_car_x <= ({1'b0, h_pos} >= ScrW) ? 10'd0 : h_pos;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_car_pixel <= 1'b0;
    end else begin
      r_car_pixel <= w_car_on;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overlap_flag <= 1'b0;
    end else if (clear_hit || vsync_pulse) begin
      r_overlap_flag <= 1'b0;
    end else if (w_car_on && w_chick_on) begin
      r_overlap_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StSafe;
      r_frame_cnt <= '0;
      r_hit       <= 1'b0;
      r_hit_pulse <= 1'b0;
    end else begin
      r_hit_pulse <= 1'b0;
      if (clear_hit) begin
        r_state     <= StSafe;
        r_frame_cnt <= '0;
        r_hit       <= 1'b0;
      end else if (vsync_pulse) begin
        case (r_state)
          StSafe: begin
            if (r_overlap_flag) begin
              if (HIT_FRAMES == 32'd1) begin
                r_state     <= StHit;
                r_hit       <= 1'b1;
                r_hit_pulse <= 1'b1;
              end else begin
                r_state     <= StContact;
                r_frame_cnt <= CntW'(1);
              end
            end
          end
          StContact: begin
            if (r_overlap_flag) begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
              if (r_frame_cnt + 1'b1 == HitCnt) begin
                r_state     <= StHit;
                r_hit       <= 1'b1;
                r_hit_pulse <= 1'b1;
              end
            end else begin
              r_state     <= StSafe;
              r_frame_cnt <= '0;
            end
          end
          StHit: r_state <= StHit;
          default: begin
            r_state     <= StSafe;
            r_frame_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign car_pixel = r_car_pixel;
  assign hit       = r_hit;
  assign hit_pulse = r_hit_pulse;

endmodule
